store_queue_ctrl: RTL and testbench

STORE_QUEUE_CTRL -- requirements
Module: store_queue_ctrl

---
 rtl/store_queue_ctrl_if.sv | 39 +++
 rtl/store_queue_ctrl.sv | 144 ++++++++++++++
 tb/tb_store_queue_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_queue_ctrl_if.sv
// Store-queue interface: the execute-side store handshake, the memory write port,
// and the drain/status signals, bundled so the controller and its environment share one definition.
interface store_queue_ctrl_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          st_valid;
    logic          st_ready;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    logic [1:0]    st_sel;

    logic          drain_req;
    logic          drained;

    logic          mem_req;
    logic          mem_gnt;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;

    logic          misalign_err;
    logic [CW-1:0] count;
    logic          empty;

    modport slave (
        input  st_valid, st_addr, st_data, st_sel, drain_req, mem_gnt,
        output st_ready, drained, mem_req, mem_addr, mem_wdata, mem_be,
               misalign_err, count, empty
    );

    modport master (
        output st_valid, st_addr, st_data, st_sel, drain_req, mem_gnt,
        input  st_ready, drained, mem_req, mem_addr, mem_wdata, mem_be,
               misalign_err, count, empty
    );
endinterface

// File: rtl/store_queue_ctrl.sv
// Store queue between execute and memory: formats sub-word stores into lane-replicated
// words with byte enables, issues them in order, and supports a drain handshake for fences.
module store_queue_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    store_queue_ctrl_if.slave sq
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
        $error("store_queue_ctrl: DEPTH must be a power of two in 2..16");
    end

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic          misErr_q, misErr_d;
    logic          armed_q, armed_d;

    logic [AW-3:0] addrMem [DEPTH];
    logic [31:0]   dataMem [DEPTH];
    logic [3:0]    beMem   [DEPTH];

    logic          full;
    logic          ready;
    logic          memReq;
    logic          accept;
    logic          misaligned;
    logic          push;
    logic          pop;
    logic          drainTrig;
    logic          drainDone;
    logic [31:0]   fmtData;
    logic [3:0]    fmtBe;

    always_comb begin
        fmtData    = sq.st_data;
        fmtBe      = 4'b1111;
        misaligned = 1'b0;
        case (sq.st_sel)
            2'b10: begin
                fmtData = {4{sq.st_data[7:0]}};
                fmtBe   = 4'b0001 << sq.st_addr[1:0];
            end
            2'b01: begin
                fmtData    = {2{sq.st_data[15:0]}};
                fmtBe      = sq.st_addr[1] ? 4'b1100 : 4'b0011;
                misaligned = sq.st_addr[0];
            end
            default: begin
                misaligned = (sq.st_addr[1:0] != 2'b00);
            end
        endcase
    end

    // Space freed by a pop only becomes visible next cycle, keeping st_ready off the mem_gnt path.
    assign full   = (count_q == CW'(DEPTH));
    assign ready  = !full && (state_q == RUN);
    assign memReq = (count_q != '0);
    assign accept = sq.st_valid && ready;
    assign push   = accept && !misaligned;
    assign pop    = memReq && sq.mem_gnt;

    always_comb begin
        wrPtr_d  = wrPtr_q + PW'(push);
        rdPtr_d  = rdPtr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        misErr_d = accept && misaligned;
    end

    always_comb begin
        state_d   = state_q;
        drainDone = 1'b0;
        armed_d   = armed_q;
        drainTrig = sq.drain_req && armed_q && (state_q == RUN);
        case (state_q)
            RUN: begin
                if (drainTrig) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (count_q == '0) begin
                    state_d   = RUN;
                    drainDone = 1'b1;
                end
            end
        endcase
        // A held drain_req must be seen low once before it may start another drain.
        if (!sq.drain_req) begin
            armed_d = 1'b1;
        end else if (drainTrig) begin
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RUN;
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            misErr_q <= 1'b0;
            armed_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            count_q  <= count_d;
            misErr_q <= misErr_d;
            armed_q  <= armed_d;
        end
    end

    // Entry storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            addrMem[wrPtr_q] <= sq.st_addr[AW-1:2];
            dataMem[wrPtr_q] <= fmtData;
            beMem[wrPtr_q]   <= fmtBe;
        end
    end

    assign sq.st_ready     = ready;
    assign sq.mem_req      = memReq;
    assign sq.mem_addr     = {addrMem[rdPtr_q], 2'b00};
    assign sq.mem_wdata    = dataMem[rdPtr_q];
    assign sq.mem_be       = beMem[rdPtr_q];
    assign sq.misalign_err = misErr_q;
    assign sq.drained      = drainDone;
    assign sq.count        = count_q;
    assign sq.empty        = (count_q == '0);

endmodule

// File: tb/tb_store_queue_ctrl.sv
// Randomised and directed bench for store_queue_ctrl: a queue-based reference model predicts
// every cycle's status, and a scoreboard matches each granted write against accepted stores.
module tb_store_queue_ctrl;
    localparam int DEPTH = 4;
    localparam int AW    = 32;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    be;
    } wr_t;

    logic clk;
    logic reset_n;
    logic started;

    int compared;
    int mismatched;

    wr_t mQ[$];
    wr_t sbQ[$];
    int  errPending;
    bit  mDrain;
    bit  mArmed;
    bit  mErr;

    store_queue_ctrl_if #(.DEPTH(DEPTH), .AW(AW)) sq ();

    store_queue_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sq      (sq.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Byte-lane view of a store: the access covers n bytes starting at its natural offset,
    // and every lane carries data byte (lane mod n).
    function automatic wr_t fmtStore(input logic [AW-1:0] a, input logic [31:0] d, input logic [1:0] s);
        wr_t e;
        int  n;
        int  off;
        n   = (s == 2'b10) ? 1 : (s == 2'b01) ? 2 : 4;
        off = int'(a[1:0]) - (int'(a[1:0]) % n);
        e.addr       = a;
        e.addr[1:0]  = 2'b00;
        for (int i = 0; i < 4; i++) begin
            e.be[i]          = (i >= off) && (i < off + n);
            e.wdata[8*i +: 8] = d[8*(i % n) +: 8];
        end
        return e;
    endfunction

    function automatic bit isMisaligned(input logic [AW-1:0] a, input logic [1:0] s);
        int n;
        n = (s == 2'b10) ? 1 : (s == 2'b01) ? 2 : 4;
        return (int'(a[1:0]) % n) != 0;
    endfunction

    task automatic modelStep(input logic v, input logic [AW-1:0] a, input logic [31:0] d,
                             input logic [1:0] s, input logic g, input logic dr);
        bit accept;
        bit pop;
        bit wasEmpty;
        bit trig;
        wasEmpty = (mQ.size() == 0);
        accept   = v && (mQ.size() < DEPTH) && !mDrain;
        pop      = !wasEmpty && g;
        trig     = !mDrain && dr && mArmed;
        mErr     = accept && isMisaligned(a, s);
        if (mErr) errPending++;
        if (mDrain) begin
            if (wasEmpty) mDrain = 1'b0;
        end else if (trig) begin
            mDrain = 1'b1;
        end
        if (!dr) mArmed = 1'b1;
        else if (trig) mArmed = 1'b0;
        if (pop) void'(mQ.pop_front());
        if (accept && !isMisaligned(a, s)) begin
            mQ.push_back(fmtStore(a, d, s));
            sbQ.push_back(fmtStore(a, d, s));
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [AW-1:0] a, input logic [31:0] d,
                                 input logic [1:0] s, input logic g, input logic dr);
        sq.st_valid  = v;
        sq.st_addr   = a;
        sq.st_data   = d;
        sq.st_sel    = s;
        sq.mem_gnt   = g;
        sq.drain_req = dr;
        @(posedge clk);
        #1;
        modelStep(v, a, d, s, g, dr);
    endtask

    task automatic idle(input int cycles, input logic g);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, '0, '0, 2'b00, g, 1'b0);
    endtask

    task automatic resetModel();
        mQ.delete();
        sbQ.delete();
        errPending = 0;
        mDrain     = 1'b0;
        mArmed     = 1'b1;
        mErr       = 1'b0;
    endtask

    task automatic doReset();
        started      = 1'b0;
        reset_n      = 1'b0;
        sq.st_valid  = 1'b0;
        sq.mem_gnt   = 1'b0;
        sq.drain_req = 1'b0;
        #1;
        checkOutput("rst_mem_req", sq.mem_req, 0);
        checkOutput("rst_count", sq.count, 0);
        checkOutput("rst_empty", sq.empty, 1);
        checkOutput("rst_misalign", sq.misalign_err, 0);
        checkOutput("rst_drained", sq.drained, 0);
        resetModel();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        started = 1'b1;
    endtask

    // Monitor: cycle-level status against the model, plus scoreboard pops on each granted write.
    always @(negedge clk) begin
        if (reset_n && started) begin
            checkOutput("st_ready", sq.st_ready, (mQ.size() < DEPTH) && !mDrain);
            checkOutput("count", sq.count, mQ.size());
            checkOutput("empty", sq.empty, mQ.size() == 0);
            checkOutput("mem_req", sq.mem_req, mQ.size() != 0);
            checkOutput("drained", sq.drained, mDrain && (mQ.size() == 0));
            checkOutput("misalign_err", sq.misalign_err, mErr);
            if (mQ.size() != 0) begin
                checkOutput("head_addr", sq.mem_addr, mQ[0].addr);
                checkOutput("head_wdata", sq.mem_wdata, mQ[0].wdata);
                checkOutput("head_be", sq.mem_be, mQ[0].be);
            end
            if (sq.mem_req && sq.mem_gnt) begin
                if (sbQ.size() == 0) begin
                    checkOutput("sb_unexpected_write", 1, 0);
                end else begin
                    wr_t e;
                    e = sbQ.pop_front();
                    checkOutput("sb_addr", sq.mem_addr, e.addr);
                    checkOutput("sb_wdata", sq.mem_wdata, e.wdata);
                    checkOutput("sb_be", sq.mem_be, e.be);
                end
            end
            if (sq.misalign_err) begin
                if (errPending == 0) checkOutput("sb_unexpected_err", 1, 0);
                else errPending--;
            end
        end
    end

    initial begin
        compared     = 0;
        mismatched   = 0;
        started      = 1'b0;
        reset_n      = 1'b0;
        sq.st_valid  = 1'b0;
        sq.st_addr   = '0;
        sq.st_data   = '0;
        sq.st_sel    = 2'b00;
        sq.mem_gnt   = 1'b0;
        sq.drain_req = 1'b0;
        resetModel();
        #3;
        checkOutput("por_mem_req", sq.mem_req, 0);
        checkOutput("por_count", sq.count, 0);
        checkOutput("por_empty", sq.empty, 1);
        checkOutput("por_drained", sq.drained, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        started = 1'b1;

        $display("[TB] sub-word formatting");
        applyStimulus(1'b1, 32'h103, 32'h0000_00A5, 2'b10, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h202, 32'h0000_1234, 2'b01, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h300, 32'hDEAD_BEEF, 2'b11, 1'b0, 1'b0);
        idle(5, 1'b1);

        $display("[TB] misaligned word and half");
        applyStimulus(1'b1, 32'h101, 32'h1111_1111, 2'b00, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h203, 32'h2222_2222, 2'b01, 1'b1, 1'b0);
        idle(3, 1'b1);

        $display("[TB] fill under backpressure");
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, AW'(32'h400 + 4 * i), 32'hC0DE_0000 + 32'(i), 2'b00, 1'b0, 1'b0);
        idle(3, 1'b0);
        idle(6, 1'b1);

        $display("[TB] simultaneous push/pop and wrap");
        applyStimulus(1'b1, 32'h500, 32'hA0, 2'b10, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h504, 32'hA1, 2'b10, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, AW'(32'h510 + i), 32'hB0 + 32'(i), 2'b10, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, AW'(32'h600 + 2 * i), 32'h5A00 + 32'(i), 2'b01, logic'($urandom_range(0, 1)), 1'b0);
        idle(12, 1'b1);

        $display("[TB] drain with entries and when empty");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, AW'(32'h700 + 4 * i), 32'h7700 + 32'(i), 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h7F0, 32'h1, 2'b00, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h7F4, 32'h2, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 32'h7F8, 32'h3, 2'b00, 1'b1, 1'b1);
        idle(2, 1'b1);
        applyStimulus(1'b0, '0, '0, 2'b00, 1'b1, 1'b1);
        idle(3, 1'b1);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, AW'(32'h800 + 4 * i), 32'h8800 + 32'(i), 2'b00, 1'b0, 1'b0);
        doReset();
        idle(3, 1'b1);
        applyStimulus(1'b1, 32'h900, 32'h9999, 2'b00, 1'b1, 1'b0);
        idle(3, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] a;
            logic [1:0]    s;
            a = AW'($urandom_range(0, 1023));
            s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (s == 2'b01) a[0] = 1'b0;
                else if (s != 2'b10) a[1:0] = 2'b00;
            end
            if (i == 300) doReset();
            applyStimulus(logic'($urandom_range(0, 3) != 0), a, $urandom, s,
                          logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 24) == 0));
        end

        for (int i = 0; i < 3 * DEPTH + 4; i++) begin
            if (mQ.size() != 0 || mDrain) applyStimulus(1'b0, '0, '0, 2'b00, 1'b1, 1'b0);
        end
        idle(2, 1'b1);
        checkOutput("sb_leftover", sbQ.size(), 0);
        checkOutput("err_leftover", errPending, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
